// File: rtl/bsearch_pkg.sv
// bsearch_pkg: shared types and constants for the binary-search engine.
//   state_e     : engine FSM states
//   cmp_e       : result of comparing a probed entry against the key
//   MEM_LAT_MAX : largest supported memory read latency
package bsearch_pkg;

    localparam int unsigned MEM_LAT_MAX = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        COMPARE,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        LT,
        GT,
        EQ
    } cmp_e;

endpackage

// File: rtl/bsearch_if.sv
// bsearch_if: request/result handshake plus memory read port of bsearch_engine.
//   start, key       : search request (controller -> engine)
//   busy, done       : engine status, done is a one-cycle pulse
//   found, index     : search result, held until the next accepted start
//   mem_addr, mem_rd : probe address and read strobe (engine -> memory)
//   mem_data         : read data, valid MEM_LAT cycles after mem_rd
// master = controller/memory side, slave = engine side.
interface bsearch_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
);
    logic              start;
    logic [DATA_W-1:0] key;
    logic              busy;
    logic              done;
    logic              found;
    logic [ADDR_W:0]   index;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output start, key, mem_data,
        input  busy, done, found, index, mem_addr, mem_rd
    );

    modport slave (
        input  start, key, mem_data,
        output busy, done, found, index, mem_addr, mem_rd
    );
endinterface

// File: rtl/bsearch_lat_ctr.sv
// bsearch_lat_ctr: reusable memory-latency down-counter.
//   clk, clr : clock, asynchronous active-low reset
//   load     : load load_val (asserted in the cycle the read is issued)
//   load_val : remaining wait cycles, i.e. read latency - 1
//   expire   : high in the last wait cycle, so the caller leaves its wait
//              state exactly when read data becomes valid
module bsearch_lat_ctr
    import bsearch_pkg::*;
#(
    parameter int unsigned CNT_W = $clog2(MEM_LAT_MAX)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign expire = (cnt_q <= CNT_W'(1));
endmodule

// File: rtl/bsearch_engine.sv
// bsearch_engine: binary search over an ascending-sorted synchronous-read memory.
//   clk : rising-edge clock
//   clr : asynchronous active-low reset
//   bus : bsearch_if.slave (start/key/busy/done/found/index, mem_addr/mem_rd/mem_data)
// Parameters: DATA_W entry/key width (unsigned compare), ADDR_W address width
// (DEPTH = 2**ADDR_W), MEM_LAT read latency 1..4.
// Optional macro BSEARCH_LOWER_BOUND_EN: keep searching after a match and report
// the first occurrence, or the insertion point (0..DEPTH) when absent.
module bsearch_engine
    import bsearch_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic      clk,
    input  logic      clr,
    bsearch_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = $clog2(MEM_LAT_MAX);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   lo_q, lo_d, hi_q, hi_d, index_q, index_d;
    logic [ADDR_W:0]   mid;
    logic [DATA_W-1:0] key_q, key_d;
    logic              found_q, found_d;
    logic              accept, lat_expire;
    cmp_e              cmp;
`ifdef BSEARCH_LOWER_BOUND_EN
    logic              match_q, match_d;
`endif

    // lo < hi <= DEPTH while searching, so lo+hi fits in ADDR_W+1 bits.
    assign mid    = (lo_q + hi_q) >> 1;
    assign accept = bus.start && (state_q == IDLE || state_q == DONE);
    assign cmp    = (bus.mem_data < key_q) ? LT :
                    (bus.mem_data > key_q) ? GT : EQ;

    bsearch_lat_ctr #(.CNT_W(CNT_W)) u_lat_ctr (
        .clk      (clk),
        .clr      (clr),
        .load     (state_q == ISSUE),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .expire   (lat_expire)
    );

    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        key_d   = key_q;
        found_d = found_q;
        index_d = index_q;
`ifdef BSEARCH_LOWER_BOUND_EN
        match_d = match_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = ISSUE;
                    lo_d    = '0;
                    hi_d    = (ADDR_W+1)'(DEPTH);
                    key_d   = bus.key;
                    found_d = 1'b0;
                    index_d = '0;
`ifdef BSEARCH_LOWER_BOUND_EN
                    match_d = 1'b0;
`endif
                end
            end
            ISSUE:   state_d = (MEM_LAT > 1) ? WAIT : COMPARE;
            WAIT:    if (lat_expire) state_d = COMPARE;
            COMPARE: begin
                unique case (cmp)
                    LT: lo_d = mid + (ADDR_W+1)'(1);
                    GT: hi_d = mid;
                    default: begin
`ifdef BSEARCH_LOWER_BOUND_EN
                        match_d = 1'b1;
                        hi_d    = mid;
`else
                        found_d = 1'b1;
                        index_d = mid;
`endif
                    end
                endcase
`ifdef BSEARCH_LOWER_BOUND_EN
                if (lo_d == hi_d) begin
                    state_d = DONE;
                    found_d = match_d;
                    index_d = lo_d;
                end else begin
                    state_d = ISSUE;
                end
`else
                state_d = (cmp == EQ || lo_d == hi_d) ? DONE : ISSUE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            key_q   <= '0;
            found_q <= 1'b0;
            index_q <= '0;
`ifdef BSEARCH_LOWER_BOUND_EN
            match_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            key_q   <= key_d;
            found_q <= found_d;
            index_q <= index_d;
`ifdef BSEARCH_LOWER_BOUND_EN
            match_q <= match_d;
`endif
        end
    end

    // Status and probe outputs decode the state register directly so that an
    // asynchronous reset drops them immediately.
    assign bus.busy     = (state_q == ISSUE) || (state_q == WAIT) || (state_q == COMPARE);
    assign bus.done     = (state_q == DONE);
    assign bus.mem_rd   = (state_q == ISSUE);
    assign bus.mem_addr = (state_q == ISSUE) ? mid[ADDR_W-1:0] : '0;
    assign bus.found    = found_q;
    assign bus.index    = index_q;
endmodule
